// File: rtl/cv32e40p_div_arbiter.sv
// Round-robin front end sharing one serial divider between NUM_REQ requesters.
// Registers the granted request, conditions operand B and tags the result with the owner id.
module cv32e40p_div_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned C_WIDTH     = 32,
    parameter int unsigned C_LOG_WIDTH = 6,
    parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RBI,
    input  logic [NUM_REQ-1:0]         Req_Vld_SI,
    output logic [NUM_REQ-1:0]         Req_Rdy_SO,
    input  logic [NUM_REQ*C_WIDTH-1:0] Req_OpA_DI,
    input  logic [NUM_REQ*C_WIDTH-1:0] Req_OpB_DI,
    input  logic [NUM_REQ*2-1:0]       Req_OpCode_DI,
    input  logic                       Flush_SI,
    output logic                       Rsp_Vld_SO,
    input  logic                       Rsp_Rdy_SI,
    output logic [ID_W-1:0]            Rsp_Id_DO,
    output logic [C_WIDTH-1:0]         Rsp_Res_DO,
    output logic                       Rsp_Err_SO,
    output logic                       Busy_SO,
    output logic [C_WIDTH-1:0]         Div_OpA_DO,
    output logic [C_WIDTH-1:0]         Div_OpB_DO,
    output logic [C_LOG_WIDTH-1:0]     Div_OpBShift_DO,
    output logic                       Div_OpBIsZero_SO,
    output logic                       Div_OpBSign_SO,
    output logic [1:0]                 Div_OpCode_DO,
    output logic                       Div_InVld_SO,
    output logic                       Div_OutRdy_SO,
    input  logic                       Div_OutVld_SI,
    input  logic [C_WIDTH-1:0]         Div_Res_DI,
    input  logic [4:0]                 Div_MemErr_DI
);

    typedef enum logic [1:0] {StArb, StIssue, StBusy, StResp} state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      id_q;
    logic [C_WIDTH-1:0]   opa_q, opb_q, res_q, res_d;
    logic [1:0]           opcode_q;
    logic                 err_q, err_d;
    logic                 discard_q, discard_d;
    logic                 load;

    logic                 grant_vld;
    logic [ID_W-1:0]      grant_idx, cand;
    logic [C_WIDTH-1:0]   sel_a, sel_b;
    logic [1:0]           sel_op;

    logic                 sgn, lz_found, div_active, mem_err;
    logic [C_WIDTH-1:0]   b_eff;
    logic [C_LOG_WIDTH-1:0] lz, shift;

    // First valid requester scanning upward from the one after the last winner.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_vld && Req_Vld_SI[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                sel_a  = Req_OpA_DI[i*C_WIDTH +: C_WIDTH];
                sel_b  = Req_OpB_DI[i*C_WIDTH +: C_WIDTH];
                sel_op = Req_OpCode_DI[i*2 +: 2];
            end
        end
    end

    assign sgn   = opcode_q[0] & opb_q[C_WIDTH-1];
    assign b_eff = sgn ? ~opb_q : opb_q;

    always_comb begin
        lz       = C_LOG_WIDTH'(C_WIDTH);
        lz_found = 1'b0;
        for (int i = C_WIDTH - 1; i >= 0; i--) begin
            if (!lz_found && b_eff[i]) begin
                lz       = C_LOG_WIDTH'(C_WIDTH - 1 - i);
                lz_found = 1'b1;
            end
        end
    end

    assign shift = (lz > C_LOG_WIDTH'(C_WIDTH - 1)) ? C_LOG_WIDTH'(C_WIDTH - 1) : lz;

    // Divider operands are only driven while an operation owns the divider.
    assign div_active       = (state_q == StIssue) || (state_q == StBusy);
    assign Div_OpA_DO       = div_active ? opa_q : '0;
    assign Div_OpB_DO       = div_active ? (opb_q << shift) : '0;
    assign Div_OpBShift_DO  = div_active ? shift : '0;
    assign Div_OpBIsZero_SO = div_active && (opb_q == '0);
    assign Div_OpBSign_SO   = div_active && sgn;
    assign Div_OpCode_DO    = div_active ? opcode_q : 2'b00;

    assign mem_err    = |Div_MemErr_DI;
    assign Busy_SO    = (state_q != StArb);
    assign Rsp_Id_DO  = id_q;
    assign Rsp_Res_DO = res_q;
    assign Rsp_Err_SO = err_q;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        err_d         = err_q;
        discard_d     = discard_q;
        res_d         = res_q;
        load          = 1'b0;
        Req_Rdy_SO    = '0;
        Div_InVld_SO  = 1'b0;
        Div_OutRdy_SO = 1'b0;
        Rsp_Vld_SO    = 1'b0;
        unique case (state_q)
            StArb: begin
                if (grant_vld) begin
                    Req_Rdy_SO[grant_idx] = 1'b1;
                    load      = 1'b1;
                    rr_ptr_d  = grant_idx;
                    err_d     = 1'b0;
                    discard_d = 1'b0;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                Div_InVld_SO = 1'b1;
                if (mem_err)  err_d     = 1'b1;
                if (Flush_SI) discard_d = 1'b1;
                state_d = StBusy;
            end
            StBusy: begin
                if (mem_err)  err_d     = 1'b1;
                if (Flush_SI) discard_d = 1'b1;
                if (Div_OutVld_SI) begin
                    Div_OutRdy_SO = 1'b1;
                    res_d         = Div_Res_DI;
                    state_d       = (discard_q || Flush_SI) ? StArb : StResp;
                end
            end
            StResp: begin
                Rsp_Vld_SO = 1'b1;
                if (Flush_SI || Rsp_Rdy_SI) state_d = StArb;
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            state_q   <= StArb;
            rr_ptr_q  <= ID_W'(NUM_REQ - 1);
            id_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            opcode_q  <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            res_q     <= res_d;
            err_q     <= err_d;
            discard_q <= discard_d;
            if (load) begin
                id_q     <= grant_idx;
                opa_q    <= sel_a;
                opb_q    <= sel_b;
                opcode_q <= sel_op;
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_div_arbiter.sv
// Scoreboard bench: round-robin/latency/result reference model plus a behavioural serial divider.
module tb_cv32e40p_div_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
    } op_t;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] res;
        logic         err;
        logic         disc;
        int           gcyc;
        int           shift;
    } rec_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_vld, req_rdy;
    logic [NREQ*W-1:0]   req_opa, req_opb;
    logic [NREQ*2-1:0]   req_op;
    logic                flush, rsp_vld, rsp_rdy, rsp_err, busy;
    logic [0:0]          rsp_id;
    logic [W-1:0]        rsp_res, div_opa, div_opb, div_res;
    logic [5:0]          div_shift;
    logic                div_zero, div_sign, div_invld, div_outrdy, div_outvld;
    logic [1:0]          div_op;
    logic [4:0]          div_memerr;

    cv32e40p_div_arbiter #(.NUM_REQ(NREQ), .C_WIDTH(W), .C_LOG_WIDTH(6)) dut (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .Req_Vld_SI(req_vld), .Req_Rdy_SO(req_rdy),
        .Req_OpA_DI(req_opa), .Req_OpB_DI(req_opb), .Req_OpCode_DI(req_op),
        .Flush_SI(flush),
        .Rsp_Vld_SO(rsp_vld), .Rsp_Rdy_SI(rsp_rdy), .Rsp_Id_DO(rsp_id),
        .Rsp_Res_DO(rsp_res), .Rsp_Err_SO(rsp_err), .Busy_SO(busy),
        .Div_OpA_DO(div_opa), .Div_OpB_DO(div_opb), .Div_OpBShift_DO(div_shift),
        .Div_OpBIsZero_SO(div_zero), .Div_OpBSign_SO(div_sign), .Div_OpCode_DO(div_op),
        .Div_InVld_SO(div_invld), .Div_OutRdy_SO(div_outrdy),
        .Div_OutVld_SI(div_outvld), .Div_Res_DI(div_res), .Div_MemErr_DI(div_memerr)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    op_t  rq [NREQ][$];
    rec_t exp_q[$];
    int   grant_log[$], grant_cyc_log[$];
    logic [NREQ-1:0] gflag = '0;
    int   rr_m = NREQ - 1, gcount = 0, n_outrdy = 0, n_rsp = 0;
    logic prev_rsp = 1'b0, rnd_on = 1'b0;
    int   last_iss_shift, last_rsp_lat;
    logic [W-1:0] last_iss_opb, last_rsp_res;
    logic last_iss_sign, last_iss_zero, last_rsp_err;
    int   last_rsp_id;
    // Samples handed from the negedge monitor to the divider model.
    logic s_issue = 0, s_hs = 0, s_rst = 0;
    int   s_shift = 0;
    logic [W-1:0] s_res = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
        logic [W-1:0] min_int = {1'b1, {(W-1){1'b0}}};
        case (op)
            2'd0: return (b == 0) ? '1 : a / b;
            2'd1: begin
                if (b == 0) return '1;
                if (a == min_int && b == '1) return min_int;
                return $signed(a) / $signed(b);
            end
            2'd2: return (b == 0) ? a : a % b;
            default: begin
                if (b == 0) return a;
                if (a == min_int && b == '1) return '0;
                return $signed(a) % $signed(b);
            end
        endcase
    endfunction

    function automatic void cond(input logic [W-1:0] b, input logic [1:0] op, output int sh,
                                 output logic [W-1:0] ob, output logic sg);
        logic [W-1:0] be;
        int lz = W;
        sg = op[0] & b[W-1];
        be = sg ? ~b : b;
        for (int i = W - 1; i >= 0; i--) begin
            if (be[i]) begin
                lz = W - 1 - i;
                break;
            end
        end
        sh = (lz > W - 1) ? W - 1 : lz;
        ob = b << sh;
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        int w, sh;
        logic [W-1:0] ob;
        logic sg;
        logic [NREQ-1:0] oh;
        s_issue = 1'b0;
        s_hs    = 1'b0;
        s_rst   = !rst_n;
        if (!rst_n) begin
            exp_q.delete();
            rr_m     = NREQ - 1;
            gflag    = '0;
            prev_rsp = 1'b0;
        end else begin
            if (exp_q.size() > 0 && cyc >= exp_q[0].gcyc + 1 &&
                cyc <= exp_q[0].gcyc + 3 + exp_q[0].shift) begin
                if (|div_memerr) exp_q[0].err = 1'b1;
                if (flush) exp_q[0].disc = 1'b1;
            end
            if (div_invld) begin
                if (exp_q.size() == 0) chk("iss_unexpected", 1, 0);
                else begin
                    cond(exp_q[0].b, exp_q[0].op, sh, ob, sg);
                    chk("iss_cycle", cyc, exp_q[0].gcyc + 1);
                    chk("iss_opa", div_opa, exp_q[0].a);
                    chk("iss_opb", div_opb, ob);
                    chk("iss_shift", div_shift, sh);
                    chk("iss_zero", div_zero, exp_q[0].b == 0);
                    chk("iss_sign", div_sign, sg);
                    chk("iss_op", div_op, exp_q[0].op);
                    last_iss_shift = div_shift;
                    last_iss_opb   = div_opb;
                    last_iss_sign  = div_sign;
                    last_iss_zero  = div_zero;
                    s_issue = 1'b1;
                    s_shift = sh;
                    s_res   = ref_res(div_opa, exp_q[0].b, div_op);
                end
            end
            if (div_outrdy) begin
                n_outrdy++;
                chk("outrdy_without_outvld", div_outvld, 1);
                s_hs = div_outvld;
                if (exp_q.size() > 0 && exp_q[0].disc) void'(exp_q.pop_front());
            end
            if (rsp_vld) begin
                if (exp_q.size() == 0 || exp_q[0].disc) chk("rsp_unexpected", 1, 0);
                else begin
                    if (!prev_rsp) begin
                        last_rsp_lat = cyc - exp_q[0].gcyc;
                        chk("rsp_latency", last_rsp_lat, 4 + exp_q[0].shift);
                    end
                    chk("rsp_id", rsp_id, exp_q[0].id);
                    chk("rsp_res", rsp_res, exp_q[0].res);
                    chk("rsp_err", rsp_err, exp_q[0].err);
                    last_rsp_id  = rsp_id;
                    last_rsp_res = rsp_res;
                    last_rsp_err = rsp_err;
                    if (rsp_rdy) n_rsp++;
                    if (rsp_rdy || flush) void'(exp_q.pop_front());
                end
            end
            prev_rsp = rsp_vld;
            if (!busy) begin
                if (req_vld != 0) begin
                    w = 0;
                    for (int k = 1; k <= NREQ; k++) begin
                        if (req_vld[(rr_m + k) % NREQ]) begin
                            w = (rr_m + k) % NREQ;
                            break;
                        end
                    end
                    oh = '0;
                    oh[w] = 1'b1;
                    chk("grant", req_rdy, oh);
                    begin
                        rec_t r;
                        r.id   = w;
                        r.a    = req_opa[w*W +: W];
                        r.b    = req_opb[w*W +: W];
                        r.op   = req_op[w*2 +: 2];
                        r.res  = ref_res(r.a, r.b, r.op);
                        r.err  = 1'b0;
                        r.disc = 1'b0;
                        r.gcyc = cyc;
                        cond(r.b, r.op, r.shift, ob, sg);
                        exp_q.push_back(r);
                    end
                    gflag[w] = 1'b1;
                    rr_m = w;
                    gcount++;
                    grant_log.push_back(w);
                    grant_cyc_log.push_back(cyc);
                end else chk("rdy_idle", req_rdy, 0);
            end else chk("rdy_busy", req_rdy, 0);
        end
    end

    // Behavioural serial divider: result valid shift+2 cycles after the issue cycle.
    initial begin
        logic d_act = 1'b0;
        int d_cnt = 0;
        logic [W-1:0] d_res = '0;
        div_outvld = 1'b0;
        div_res    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (s_rst) begin
                div_outvld = 1'b0;
                d_act = 1'b0;
            end else begin
                if (s_hs) div_outvld = 1'b0;
                if (d_act) begin
                    if (d_cnt == 0) begin
                        div_outvld = 1'b1;
                        div_res = d_res;
                        d_act = 1'b0;
                    end else d_cnt--;
                end
                if (s_issue) begin
                    d_act = 1'b1;
                    d_cnt = s_shift;
                    d_res = s_res;
                end
            end
        end
    end

    // Requester driver: hold each queued op valid until granted.
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (gflag[i]) begin
                gflag[i] = 1'b0;
                req_vld[i] = 1'b0;
                if (rq[i].size() > 0) void'(rq[i].pop_front());
            end
            if (!req_vld[i] && rq[i].size() > 0) begin
                req_vld[i] = 1'b1;
                req_opa[i*W +: W] = rq[i][0].a;
                req_opb[i*W +: W] = rq[i][0].b;
                req_op[i*2 +: 2]  = rq[i][0].op;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_on) begin
            rsp_rdy    = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            div_memerr = ($urandom_range(0, 29) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
        end
    end

    task automatic push_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op);
        op_t o;
        o.a = a;
        o.b = b;
        o.op = op;
        rq[r].push_back(o);
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #2;
            if (rq[0].size() == 0 && rq[1].size() == 0 && req_vld == 0 && exp_q.size() == 0
                && !busy) return;
        end
        chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_grant(output int g);
        int gc0 = gcount;
        g = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #2;
            if (gcount != gc0) begin
                g = grant_cyc_log[$];
                return;
            end
        end
        chk("wait_grant_timeout", 1, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_res", rsp_res, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_invld", div_invld, 0);
        chk("rst_outrdy", div_outrdy, 0);
        chk("rst_div_data", {div_opa, div_opb}, 0);
        chk("rst_div_ctl", {div_shift, div_zero, div_sign, div_op}, 0);
    endtask

    function automatic logic [W-1:0] rand_b();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return W'($urandom_range(1, 15));
            2: return W'($urandom);
            3: return '1;
            default: return W'($urandom) >> $urandom_range(0, W - 1);
        endcase
    endfunction

    initial begin
        int g, r0, o0, gs;
        rst_n = 1'b0;
        req_vld = '0;
        req_opa = '0;
        req_opb = '0;
        req_op = '0;
        flush = 1'b0;
        rsp_rdy = 1'b1;
        div_memerr = '0;
        repeat (3) @(posedge clk);
        #2 chk_reset_vals();
        rst_n = 1'b1;

        push_op(0, 100, 7, 2'd0);
        wait_idle(200);
        chk("t1_shift", last_iss_shift, 29);
        chk("t1_opb", last_iss_opb, 32'hE000_0000);
        chk("t1_id", last_rsp_id, 0);
        chk("t1_res", last_rsp_res, 14);
        chk("t1_lat", last_rsp_lat, 33);
        chk("t1_err", last_rsp_err, 0);

        push_op(1, 32'hFFFF_FFF9, 2, 2'd3);
        wait_idle(200);
        chk("t2_sign", last_iss_sign, 0);
        chk("t2_shift", last_iss_shift, 30);
        chk("t2_id", last_rsp_id, 1);
        chk("t2_res", last_rsp_res, 32'hFFFF_FFFF);

        gs = grant_log.size();
        for (int k = 0; k < 3; k++) begin
            push_op(0, W'($urandom), W'($urandom_range(1, 200)), 2'(k));
            push_op(1, W'($urandom), W'($urandom_range(1, 200)), 2'(k + 1));
        end
        wait_idle(1000);
        for (int k = 0; k < 6; k++) chk("alt_order", grant_log[gs + k], k % 2);

        rsp_rdy = 1'b0;
        push_op(0, 5, 0, 2'd1);
        push_op(1, 9, 3, 2'd0);
        for (int n = 0; n < 100 && !rsp_vld; n++) begin
            @(posedge clk);
            #2;
        end
        chk("t4_zero", last_iss_zero, 1);
        repeat (10) begin
            chk("bp_vld", rsp_vld, 1);
            chk("bp_res", rsp_res, 32'hFFFF_FFFF);
            chk("bp_rdy", req_rdy, 0);
            @(posedge clk);
            #2;
        end
        rsp_rdy = 1'b1;
        wait_idle(200);

        rsp_rdy = 1'b0;
        push_op(0, 77, 5, 2'd2);
        for (int n = 0; n < 100 && !rsp_vld; n++) begin
            @(posedge clk);
            #2;
        end
        flush = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
        chk("resp_flush_drop", rsp_vld, 0);
        rsp_rdy = 1'b1;
        wait_idle(200);

        o0 = n_outrdy;
        r0 = n_rsp;
        push_op(0, 100, 7, 2'd0);
        wait_grant(g);
        push_op(1, 1234, 11, 2'd2);
        repeat (3) @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
        wait_idle(300);
        chk("flush_outrdy", n_outrdy - o0, 2);
        chk("flush_rsp_cnt", n_rsp - r0, 1);
        chk("flush_regrant", grant_cyc_log[$] - grant_cyc_log[$-1], 33);

        push_op(0, 1000, 3, 2'd0);
        wait_grant(g);
        @(posedge clk);
        #2 div_memerr = 5'b00100;
        @(posedge clk);
        #2 div_memerr = '0;
        wait_idle(200);
        chk("err_set", last_rsp_err, 1);
        push_op(1, 1000, 3, 2'd0);
        wait_idle(200);
        chk("err_clear", last_rsp_err, 0);

        push_op(0, 1000, 3, 2'd0);
        wait_grant(g);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 chk_reset_vals();
        rst_n = 1'b1;
        push_op(1, 1000, 3, 2'd2);
        wait_idle(200);
        chk("post_rst_res", last_rsp_res, 1);
        chk("post_rst_id", last_rsp_id, 1);

        rnd_on = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int r = $urandom_range(0, 1);
            push_op(r, ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : W'($urandom), rand_b(),
                    2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0)
                push_op(1 - r, W'($urandom), rand_b(), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 40)) @(posedge clk);
        end
        rnd_on = 1'b0;
        #2;
        rsp_rdy = 1'b1;
        flush = 1'b0;
        div_memerr = '0;
        wait_idle(20000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        n_err++;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
